// File: rtl/lu_sched_if.sv
// Command/acknowledge bus between the LU scheduler and the LU datapath.
// The scheduler drives commands; the datapath returns ready and per-op ack.
interface lu_sched_if;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_type;
  logic [7:0] k_idx;
  logic [7:0] i_idx;
  logic [7:0] j_idx;
  logic       ack;

  modport master (
    output op_valid, op_type, k_idx, i_idx, j_idx,
    input  op_ready, ack
  );

  modport slave (
    input  op_valid, op_type, k_idx, i_idx, j_idx,
    output op_ready, ack
  );
endinterface

// File: rtl/lu_sched.sv
// LU factorisation command scheduler: walks pivot, scale and update loops per
// column k, limiting in-flight datapath ops to MAX_OUT and draining between phases.
module lu_sched #(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  n_dim,
  lu_sched_if.master  op,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PIVOT, S_DRAIN_P, S_SCALE, S_DRAIN_S, S_UPDATE, S_DRAIN_U, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_PIVOT  = 2'b01,
    OP_SCALE  = 2'b10,
    OP_UPDATE = 2'b11
  } op_t;

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  state_t     state, state_nxt;
  logic [7:0] n_q, k_q, i_q, j_q;
  logic [3:0] outstanding;
  logic       ignore_ack;

  logic abort_now, start_ok, issuing, ack_cnt, valid, fire;
  logic last_i, last_j, drained, err_nxt;

  assign abort_now = abort && (state != S_IDLE);
  assign start_ok  = (state == S_IDLE) && start && (n_dim <= 8'd128);
  assign issuing   = (state == S_PIVOT) || (state == S_SCALE) || (state == S_UPDATE);
  // An ack only counts against a real in-flight op; a same-cycle ack frees a slot.
  assign ack_cnt   = op.ack && (outstanding != 4'd0);
  assign valid     = issuing && ((outstanding != MAX_OUT_C) || ack_cnt);
  assign fire      = valid && op.op_ready;
  assign last_i    = (i_q == n_q - 8'd1);
  assign last_j    = (j_q == n_q - 8'd1);
  assign drained   = (outstanding == 4'd0);
  // Acks left over from an aborted run are silently dropped until the next start.
  assign err_nxt   = !abort_now &&
                     (((state == S_IDLE) && start && (n_dim > 8'd128)) ||
                      (op.ack && (outstanding == 4'd0) && !ignore_ack));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_now) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start_ok) state_nxt = (n_dim < 8'd2) ? S_FIN : S_PIVOT;
        S_PIVOT:   if (fire) state_nxt = S_DRAIN_P;
        S_DRAIN_P: if (drained) state_nxt = S_SCALE;
        S_SCALE:   if (fire && last_i) state_nxt = S_DRAIN_S;
        S_DRAIN_S: if (drained) state_nxt = S_UPDATE;
        S_UPDATE:  if (fire && last_i && last_j) state_nxt = S_DRAIN_U;
        S_DRAIN_U: if (drained) state_nxt = (k_q < n_q - 8'd2) ? S_PIVOT : S_FIN;
        S_FIN:     state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q         <= 8'd0;
      k_q         <= 8'd0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      outstanding <= 4'd0;
      ignore_ack  <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= err_nxt;
      if (abort_now) begin
        k_q         <= 8'd0;
        i_q         <= 8'd0;
        j_q         <= 8'd0;
        outstanding <= 4'd0;
        ignore_ack  <= 1'b1;
      end else begin
        case ({fire, ack_cnt})
          2'b10:   outstanding <= outstanding + 4'd1;
          2'b01:   outstanding <= outstanding - 4'd1;
          default: outstanding <= outstanding;
        endcase

        if (start_ok) begin
          n_q        <= n_dim;
          k_q        <= 8'd0;
          i_q        <= 8'd1;
          j_q        <= 8'd1;
          ignore_ack <= 1'b0;
        end

        // i/j always restart at k+1, so the next phase finds them preloaded.
        case (state)
          S_SCALE: if (fire) begin
            if (last_i) begin
              i_q <= k_q + 8'd1;
              j_q <= k_q + 8'd1;
            end else begin
              i_q <= i_q + 8'd1;
            end
          end
          S_UPDATE: if (fire) begin
            if (last_j) begin
              j_q <= k_q + 8'd1;
              i_q <= i_q + 8'd1;
            end else begin
              j_q <= j_q + 8'd1;
            end
          end
          S_DRAIN_U: if (drained) begin
            k_q <= k_q + 8'd1;
            i_q <= k_q + 8'd2;
            j_q <= k_q + 8'd2;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: every output gets a default first so no path through the block
  // leaves a value unassigned and infers a latch.
  always_comb begin
    op.op_valid = valid;
    op.op_type  = OP_NONE;
    op.k_idx    = 8'd0;
    op.i_idx    = 8'd0;
    op.j_idx    = 8'd0;
    busy        = (state != S_IDLE) && (state != S_FIN);
    done        = (state == S_FIN) && !abort_now;
    if (valid) begin
      case (state)
        S_PIVOT: begin
          op.op_type = OP_PIVOT;
          op.k_idx   = k_q;
          op.i_idx   = k_q;
          op.j_idx   = k_q;
        end
        S_SCALE: begin
          op.op_type = OP_SCALE;
          op.k_idx   = k_q;
          op.i_idx   = i_q;
          op.j_idx   = k_q;
        end
        S_UPDATE: begin
          op.op_type = OP_UPDATE;
          op.k_idx   = k_q;
          op.i_idx   = i_q;
          op.j_idx   = j_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lu_sched.sv
// Scoreboard bench for lu_sched: expected command streams are queued at start,
// a datapath responder pops them on each fire and returns acks after a latency.
`timescale 1ns/1ps
module tb_lu_sched;
  localparam int MAX_OUT = 2;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] n_dim;
  logic       busy, done, err;

  lu_sched_if op_if ();

  lu_sched #(.MAX_OUT(MAX_OUT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .n_dim (n_dim),
    .op    (op_if),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  bit ack_drv   = 1'b0;
  bit ready_drv = 1'b1;
  assign op_if.ack      = ack_drv;
  assign op_if.op_ready = ready_drv;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [25:0] sb[$];
  int          due[$];
  int cyc = 0, fires = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int ack_lat = 2;
  bit ack_hold = 1'b0, release_one = 1'b0, inject_ack = 1'b0, hold_on_update = 1'b0;
  bit prev_stall = 1'b0;
  logic [25:0] prev_op;

  wire [25:0] cur_op = {op_if.op_type, op_if.k_idx, op_if.i_idx, op_if.j_idx};

  function automatic logic [25:0] mk(input logic [1:0] t, input int k, input int i, input int j);
    return {t, 8'(k), 8'(i), 8'(j)};
  endfunction

  function automatic int total_ops(input int n);
    int s = 0;
    for (int k = 0; k <= n - 2; k++) s += 1 + (n - 1 - k) + (n - 1 - k) * (n - 1 - k);
    return s;
  endfunction

  // Datapath model: ack decided at negedge+1, fire/flags sampled at negedge+3.
  always @(negedge clk) begin
    cyc++;
    #1;
    if (due.size() > 0 && due[0] <= cyc && (!ack_hold || release_one)) begin
      void'(due.pop_front());
      release_one = 1'b0;
      ack_drv = 1'b1;
    end else begin
      ack_drv = 1'b0;
    end
    if (inject_ack) begin
      ack_drv = 1'b1;
      inject_ack = 1'b0;
    end
    #2;
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (busy) busy_cnt++;
    if (prev_stall && op_if.op_valid) check("hold_stable", 32'(cur_op), 32'(prev_op));
    prev_stall = op_if.op_valid && !op_if.op_ready;
    prev_op    = cur_op;
    if (op_if.op_valid && op_if.op_ready) begin
      fires++;
      if (sb.size() == 0) check("extra_op", 32'(cur_op), 32'd0);
      else                check("op_order", 32'(cur_op), 32'(sb.pop_front()));
      due.push_back(cyc + ack_lat);
      if (hold_on_update && op_if.op_type == 2'b11) begin
        ack_hold = 1'b1;
        hold_on_update = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [7:0] n);
    @(negedge clk);
    n_dim = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_run(input int n);
    for (int k = 0; k <= n - 2; k++) begin
      sb.push_back(mk(2'b01, k, k, k));
      for (int i = k + 1; i < n; i++) sb.push_back(mk(2'b10, k, i, k));
      for (int i = k + 1; i < n; i++)
        for (int j = k + 1; j < n; j++) sb.push_back(mk(2'b11, k, i, j));
    end
  endtask

  task automatic wait_fires(input int target, input int budget);
    int b = 0;
    while (fires < target && b < budget) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int b = 0;
    while (done_cnt == d0 && b < budget) begin
      @(negedge clk);
      b++;
    end
    step(3);
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic run(input string tag, input int n, input int lat);
    int d0, f0, e0;
    ack_lat = lat;
    d0 = done_cnt; f0 = fires; e0 = err_cnt;
    push_run(n);
    pulse_start(8'(n));
    wait_done(tag, d0, 3000);
    check({tag, "_fires"}, 32'(fires - f0), 32'(total_ops(n)));
    check({tag, "_sb"}, 32'(sb.size()), 32'd0);
    check({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, f0, e0, b0, f;
    bit found;
    reset = 1'b1; start = 1'b0; abort = 1'b0; n_dim = 8'd0;

    // Reset state
    step(3);
    #4 check("reset_outputs", 32'({op_if.op_valid, busy, done, err, cur_op}), 32'd0);
    @(negedge clk) reset = 1'b0;
    step(2);

    // N=3 reference sequence, plus a start pulse while busy that must be ignored
    ack_lat = 2;
    d0 = done_cnt; f0 = fires; e0 = err_cnt;
    sb.push_back(mk(2'b01, 0, 0, 0));
    sb.push_back(mk(2'b10, 0, 1, 0));
    sb.push_back(mk(2'b10, 0, 2, 0));
    sb.push_back(mk(2'b11, 0, 1, 1));
    sb.push_back(mk(2'b11, 0, 1, 2));
    sb.push_back(mk(2'b11, 0, 2, 1));
    sb.push_back(mk(2'b11, 0, 2, 2));
    sb.push_back(mk(2'b01, 1, 1, 1));
    sb.push_back(mk(2'b10, 1, 2, 1));
    sb.push_back(mk(2'b11, 1, 2, 2));
    pulse_start(8'd3);
    #4 check("n3_busy_up", 32'(busy), 32'd1);
    check("n3_first_valid", 32'(op_if.op_valid), 32'd1);
    wait_fires(f0 + 5, 200);
    pulse_start(8'd5);
    wait_done("n3", d0, 500);
    check("n3_fires", 32'(fires - f0), 32'd10);
    check("n3_sb", 32'(sb.size()), 32'd0);
    check("n3_err", 32'(err_cnt - e0), 32'd0);
    check("n3_busy_down", 32'(busy), 32'd0);

    // Degenerate and oversized dimensions
    b0 = busy_cnt;
    run("n1", 1, 2);
    run("n0", 0, 2);
    check("n01_no_busy", 32'(busy_cnt - b0), 32'd0);
    d0 = done_cnt; f0 = fires; e0 = err_cnt; b0 = busy_cnt;
    pulse_start(8'd200);
    step(4);
    check("n200_err", 32'(err_cnt - e0), 32'd1);
    check("n200_busy", 32'(busy_cnt - b0), 32'd0);
    check("n200_done", 32'(done_cnt - d0), 32'd0);
    check("n200_fires", 32'(fires - f0), 32'd0);

    run("n2", 2, 2);

    // Outstanding limit: acks withheld from the first UPDATE fire onward
    ack_lat = 2;
    d0 = done_cnt; f0 = fires;
    push_run(4);
    hold_on_update = 1'b1;
    pulse_start(8'd4);
    for (int b = 0; b < 300 && !ack_hold; b++) @(negedge clk);
    f = fires;
    step(15);
    check("limit_two_fires", 32'(fires - f), 32'd1);
    check("limit_valid_low", 32'(op_if.op_valid), 32'd0);
    release_one = 1'b1;
    step(10);
    check("limit_one_more", 32'(fires - f), 32'd2);
    check("limit_valid_low2", 32'(op_if.op_valid), 32'd0);
    ack_hold = 1'b0;
    wait_done("limit", d0, 2000);
    check("limit_fires", 32'(fires - f0), 32'(total_ops(4)));
    check("limit_sb", 32'(sb.size()), 32'd0);

    // op_ready low for 5 cycles while SCALE i=2 is presented
    ack_lat = 2;
    d0 = done_cnt; f0 = fires;
    push_run(4);
    pulse_start(8'd4);
    found = 1'b0;
    for (int b = 0; b < 200 && !found; b++) begin
      @(negedge clk);
      #2;
      if (op_if.op_valid && cur_op == mk(2'b10, 0, 2, 0)) begin
        ready_drv = 1'b0;
        found = 1'b1;
      end
    end
    check("stall_found", 32'(found), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #4 check("stall_op", 32'(cur_op), 32'(mk(2'b10, 0, 2, 0)));
    end
    @(negedge clk) ready_drv = 1'b1;
    wait_done("stall", d0, 2000);
    check("stall_fires", 32'(fires - f0), 32'(total_ops(4)));
    check("stall_sb", 32'(sb.size()), 32'd0);

    // Abort in DRAIN_S with two ops in flight; late acks must not raise err
    ack_lat = 20;
    f0 = fires;
    push_run(3);
    pulse_start(8'd3);
    wait_fires(f0 + 3, 200);
    step(2);
    d0 = done_cnt; e0 = err_cnt;
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    #4 check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(op_if.op_valid), 32'd0);
    step(30);
    check("abort_no_err", 32'(err_cnt - e0), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    sb.delete();
    run("after_abort", 2, 2);

    // Reset mid-UPDATE, then a stray ack, then a normal run
    ack_lat = 2;
    f0 = fires;
    push_run(3);
    pulse_start(8'd3);
    wait_fires(f0 + 4, 200);
    @(negedge clk);
    #4 reset = 1'b1;
    #0.5 check("rst_mid_outputs", 32'({op_if.op_valid, busy, done, err, cur_op}), 32'd0);
    step(2);
    sb.delete();
    due.delete();
    reset = 1'b0;
    f = fires;
    step(5);
    check("rst_no_issue", 32'(fires - f), 32'd0);
    e0 = err_cnt;
    inject_ack = 1'b1;
    step(3);
    check("rst_stray_ack_err", 32'(err_cnt - e0), 32'd1);
    run("after_reset", 3, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
